// File: rtl/axi_slave_write_if.sv
// AXI write-channel bundle (AW, W, B) between a master and axi_slave_write.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

interface axi_slave_write_if;
    logic [`AXI_IDS_BITS-1:0] awid_i;
    logic [31:0]              awaddr_i;
    logic [3:0]               awlen_i;
    logic [2:0]               awsize_i;
    logic [1:0]               awburst_i;
    logic                     awvalid_i;
    logic                     awready_o;
    logic [31:0]              wdata_i;
    logic [3:0]               wstrb_i;
    logic                     wlast_i;
    logic                     wvalid_i;
    logic                     wready_o;
    logic [`AXI_IDS_BITS-1:0] bid_o;
    logic [1:0]               bresp_o;
    logic                     bvalid_o;
    logic                     bready_i;

    modport slave (
        input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        input  wdata_i, wstrb_i, wlast_i, wvalid_i,
        input  bready_i,
        output awready_o, wready_o, bid_o, bresp_o, bvalid_o
    );

    modport master (
        output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        output wdata_i, wstrb_i, wlast_i, wvalid_i,
        output bready_i,
        input  awready_o, wready_o, bid_o, bresp_o, bvalid_o
    );
endinterface

// File: rtl/axi_slave_write.sv
// AXI write slave: one outstanding burst, beats written straight into an SRAM port.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module axi_slave_write #(
    parameter int unsigned MEM_AW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_slave_write_if.slave     bus,
    input  logic                 mem_grant_i,
    output logic                 mem_cs_o,
    output logic [3:0]           mem_we_o,
    output logic [MEM_AW-1:0]    mem_a_o,
    output logic [31:0]          mem_di_o
);

    typedef enum logic [1:0] {StIdle, StWdata, StBresp} state_e;

    state_e                   r_state;
    state_e                   w_state_next;
    logic [`AXI_IDS_BITS-1:0] r_id;
    logic [MEM_AW-1:0]        r_addr;
    logic [3:0]               r_len;
    logic [3:0]               r_cnt;
    logic                     r_err;
    logic                     r_fixed;   // address holds between beats (FIXED or errored burst)

    logic w_aw_ready;
    logic w_w_ready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_last_beat;
    logic w_aw_err;
    logic w_unused_addr;

    // Handshake qualifiers; awready is gated by reset so it is low while rst is asserted.
    assign w_aw_ready  = (r_state == StIdle) & rst;
    assign w_w_ready   = (r_state == StWdata) & mem_grant_i;
    assign w_aw_hs     = bus.awvalid_i & w_aw_ready;
    assign w_w_hs      = bus.wvalid_i & w_w_ready;
    assign w_b_hs      = (r_state == StBresp) & bus.bready_i;
    assign w_last_beat = (r_cnt == r_len);
    assign w_aw_err    = bus.awburst_i[1] | (bus.awsize_i != 3'b010);

    // Byte-offset and upper address bits are outside the SRAM word space.
    assign w_unused_addr = ^{bus.awaddr_i[31:MEM_AW+2], bus.awaddr_i[1:0]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and channel outputs; B payload reads zero outside StBresp.
    always_comb begin
        w_state_next  = r_state;
        bus.awready_o = w_aw_ready;
        bus.wready_o  = w_w_ready;
        bus.bvalid_o  = 1'b0;
        bus.bid_o     = '0;
        bus.bresp_o   = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (w_aw_hs) w_state_next = StWdata;
            end
            StWdata: begin
                if (w_w_hs && w_last_beat) w_state_next = StBresp;
            end
            StBresp: begin
                bus.bvalid_o = 1'b1;
                bus.bid_o    = r_id;
                bus.bresp_o  = r_err ? 2'b10 : 2'b00;
                if (bus.bready_i) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // SRAM port is driven in the same cycle as the W handshake.
    always_comb begin
        mem_cs_o = w_w_hs;
        mem_a_o  = r_addr;
        mem_di_o = bus.wdata_i;
        mem_we_o = (w_w_hs && !r_err) ? bus.wstrb_i : 4'b0000;
    end

    // Burst context: captured at AW accept, advanced per beat, error cleared on B handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_fixed <= 1'b0;
        end else if (w_aw_hs) begin
            r_id    <= bus.awid_i;
            r_addr  <= bus.awaddr_i[MEM_AW+1:2];
            r_len   <= bus.awlen_i;
            r_cnt   <= '0;
            r_err   <= w_aw_err;
            r_fixed <= w_aw_err | (bus.awburst_i == 2'b00);
        end else if (w_w_hs) begin
            r_cnt <= r_cnt + 4'd1;
            if (!r_fixed) r_addr <= r_addr + MEM_AW'(1);
            // wlast disagreeing with the beat count poisons the response but not the beat count.
            if (bus.wlast_i != w_last_beat) r_err <= 1'b1;
        end else if (w_b_hs) begin
            r_err <= 1'b0;
        end
    end

endmodule

// File: doc/axi_slave_write.md
AXI_SLAVE_WRITE -- requirements
Module: axi_slave_write

Interface
REQ-001 Parameter MEM_AW, default 14, SHALL set the SRAM word-address width.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 awid_i  in  `AXI_IDS_BITS  write-address ID with master tag.
REQ-005 awaddr_i in 32, awlen_i in 4, awsize_i in 3, awburst_i in 2  AW payload.
REQ-006 awvalid_i in 1 / awready_o out 1  AW handshake.
REQ-007 wdata_i in 32, wstrb_i in 4, wlast_i in 1  W payload.
REQ-008 wvalid_i in 1 / wready_o out 1  W handshake.
REQ-009 bid_o out `AXI_IDS_BITS, bresp_o out 2  B payload toward the write-response mux.
REQ-010 bvalid_o out 1 / bready_i in 1  B handshake.
REQ-011 mem_grant_i  in  1  SRAM port available to the write path this cycle.
REQ-012 mem_cs_o out 1, mem_we_o out 4 (byte enables, active-high), mem_a_o out MEM_AW, mem_di_o out 32  SRAM write port.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, WDATA, BRESP.
REQ-014 IDLE: awready_o=1; on awvalid_i&awready_o, latch awid_i, awaddr_i[MEM_AW+1:2], awlen_i, awburst_i, awsize_i; clear beat counter; go to WDATA next cycle.
REQ-015 awready_o SHALL be 0 in WDATA and BRESP (one outstanding write only).
REQ-016 WDATA: wready_o = mem_grant_i; wready_o SHALL be 0 in IDLE and BRESP.
REQ-017 Beat accepted when wvalid_i&wready_o; same cycle (combinational): mem_cs_o=1, mem_a_o=current address, mem_di_o=wdata_i, mem_we_o=wstrb_i, or 4'b0 if the burst is flagged in error.
REQ-018 With no accepted beat, mem_cs_o=0 and mem_we_o=0.
REQ-019 After each accepted beat: INCR (2'b01) address +1 word; FIXED (2'b00) address unchanged; increment wraps modulo 2^MEM_AW.
REQ-020 Error flag SET at AW accept if awburst_i is 2'b10/2'b11 or awsize_i != 3'b010; error beats SHALL still be consumed with no SRAM write, using FIXED addressing.
REQ-021 Beat counter is 4 bits; the beat with counter==len is last regardless of wlast_i; go to BRESP next cycle.
REQ-022 wlast_i mismatch (1 before the final beat, or 0 on the final beat) SHALL set the error flag; no beat SHALL be dropped or added.
REQ-023 BRESP: bvalid_o=1, bid_o=latched ID, bresp_o=2'b10 (SLVERR) if error flag set, else 2'b00; all held stable until bready_i.
REQ-024 On bvalid_o&bready_i go to IDLE next cycle; error flag cleared.
REQ-025 Latency: bvalid_o rises the cycle after the last beat handshake; earliest next awready_o is the cycle after the B handshake.
REQ-026 bid_o and bresp_o SHALL read 0 outside BRESP.

Reset
REQ-027 rst low SHALL immediately (asynchronously) force IDLE, clear latched ID/address/len/counter/error, and drive bvalid_o, wready_o, mem_cs_o, mem_we_o, bid_o, bresp_o to 0.
REQ-028 awready_o SHALL be gated to 0 while rst is low and reach 1 in the first cycle after release.
REQ-029 Reset mid-burst or during BRESP SHALL abandon the transaction; no B response for it SHALL be issued afterward.

Verification
REQ-030 AW id=8'h13 addr=0x100 len=0 INCR size=2; one W 0xDEADBEEF strb=F wlast=1 -> mem_a=0x40, we=F; next cycle bvalid=1, bid=8'h13, bresp=00.
REQ-031 len=3 INCR addr=0x3FFFC (MEM_AW=14) strb 1,2,4,8 -> mem_a 0x3FFF,0x0000,0x0001,0x0002; we matches strobes; bresp=00.
REQ-032 len=1 with mem_grant_i low 3 cycles, then bready_i low 2 cycles -> wready=0 while grant low; bvalid/bid/bresp held stable until bready; awready=0 throughout.
REQ-033 awburst=2'b10 len=1 -> two beats consumed, mem_we=0 on both, bresp=2'b10; wlast=1 on beat 0 of a len=2 INCR -> three beats consumed, bresp=2'b10.
REQ-034 rst low during beat 2 of len=3 -> outputs 0 at once; after release awready=1, no bvalid until a new AW completes; new single write returns bresp=00.
